// File: rtl/pin_entry_if.sv
// -----------------------------------------------------------------------------
// pin_entry_if
// Bundle between the PIN entry controller and its surroundings: card reader,
// keypad, authenticator database and the session/status consumers.
//
//   card reader   : card_in (pulse), card_acc_num[3:0]
//   keypad        : key_valid (pulse), key_digit[3:0] (BCD), key_clear, cancel
//   authenticator : auth_found, auth_pin_ok, auth_index[3:0]   (responses)
//                   acc_num[3:0], pin[15:0]                    (queries)
//   status        : session_active, session_index[3:0], locked, pin_error,
//                   attempts_left[1:0], state_out[2:0]
//
// master : the environment (drives card/keypad/auth responses)
// slave  : the controller
// -----------------------------------------------------------------------------
interface pin_entry_if;
  logic        card_in;
  logic [3:0]  card_acc_num;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_clear;
  logic        cancel;
  logic        auth_found;
  logic        auth_pin_ok;
  logic [3:0]  auth_index;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic        session_active;
  logic [3:0]  session_index;
  logic        locked;
  logic        pin_error;
  logic [1:0]  attempts_left;
  logic [2:0]  state_out;

  modport master (
    output card_in, card_acc_num, key_valid, key_digit, key_clear, cancel,
           auth_found, auth_pin_ok, auth_index,
    input  acc_num, pin, session_active, session_index, locked, pin_error,
           attempts_left, state_out
  );

  modport slave (
    input  card_in, card_acc_num, key_valid, key_digit, key_clear, cancel,
           auth_found, auth_pin_ok, auth_index,
    output acc_num, pin, session_active, session_index, locked, pin_error,
           attempts_left, state_out
  );
endinterface

// File: rtl/pin_entry_ctrl.sv
// -----------------------------------------------------------------------------
// pin_entry_ctrl
// Card-session controller: latches the account number on card insertion,
// collects PIN_DIGITS decimal keypad digits into a binary PIN, lets the
// combinational authenticator settle for one cycle, samples its answer on the
// next, and then grants a session, retries, or locks after MAX_TRIES wrong
// PINs. GET_PIN aborts to IDLE after TIMEOUT_CYCLES cycles without a keypress.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : pin_entry_if.slave (card, keypad, authenticator, status outputs)
//
// All outputs come straight from flops. state_out encodes
// IDLE=0, GET_PIN=1, CHECK=2, GRANTED=3, LOCKED=4.
// -----------------------------------------------------------------------------
module pin_entry_ctrl #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  pin_entry_if.slave bus
);

  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0]       TRIES_INIT  = 2'(MAX_TRIES);
  localparam logic [TMO_W-1:0] TMO_INIT    = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DIGITS_LAST = CNT_W'(PIN_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_PIN = 3'd1,
    CHECK   = 3'd2,
    GRANTED = 3'd3,
    LOCKED  = 3'd4
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] digit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             check_phase;   // 0: authenticator settling, 1: sample
  logic [3:0]       acc_num_q;
  logic [15:0]      pin_q;
  logic             session_active_q;
  logic [3:0]       session_index_q;
  logic             locked_q;
  logic             pin_error_q;
  logic [1:0]       attempts_q;

  logic             digit_ok;
  logic             tmo_expire;
  logic [15:0]      pin_shift;

  assign digit_ok   = (bus.key_digit <= 4'd9);
  // The counter holds 1 on the last allowed idle cycle; leaving on that edge
  // puts the FSM in IDLE exactly TIMEOUT_CYCLES cycles after the last key.
  assign tmo_expire = !bus.key_valid && (tmo_cnt <= TMO_W'(1));
  assign pin_shift  = 16'(pin_q * 16'd10) + 16'(bus.key_digit);

  // NOTE: every register here uses <=, so all branches read the pre-edge
  // values (e.g. digit_cnt below is the count before this digit is added).
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      digit_cnt        <= '0;
      tmo_cnt          <= '0;
      check_phase      <= 1'b0;
      acc_num_q        <= '0;
      pin_q            <= '0;
      session_active_q <= 1'b0;
      session_index_q  <= '0;
      locked_q         <= 1'b0;
      pin_error_q      <= 1'b0;
      attempts_q       <= TRIES_INIT;
    end else begin
      pin_error_q <= 1'b0;

      if (state == GET_PIN) begin
        if (bus.key_valid)      tmo_cnt <= TMO_INIT;
        else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (bus.card_in) begin
            acc_num_q  <= bus.card_acc_num;
            pin_q      <= '0;
            digit_cnt  <= '0;
            attempts_q <= TRIES_INIT;
            tmo_cnt    <= TMO_INIT;
            state      <= GET_PIN;
          end
        end

        GET_PIN: begin
          if (bus.cancel || tmo_expire) begin
            state <= IDLE;
          end else if (bus.key_clear) begin
            pin_q     <= '0;
            digit_cnt <= '0;
          end else if (bus.key_valid && digit_ok) begin
            pin_q     <= pin_shift;
            digit_cnt <= digit_cnt + CNT_W'(1);
            if (digit_cnt == DIGITS_LAST) begin
              check_phase <= 1'b0;
              state       <= CHECK;
            end
          end
        end

        CHECK: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else if (!check_phase) begin
            check_phase <= 1'b1;
          end else if (!bus.auth_found) begin
            // Unknown card: report it but never count it against the tries.
            pin_error_q <= 1'b1;
            state       <= IDLE;
          end else if (bus.auth_pin_ok) begin
            session_index_q  <= bus.auth_index;
            session_active_q <= 1'b1;
            state            <= GRANTED;
          end else begin
            pin_error_q <= 1'b1;
            attempts_q  <= attempts_q - 2'd1;
            if (attempts_q <= 2'd1) begin
              locked_q <= 1'b1;
              state    <= LOCKED;
            end else begin
              pin_q     <= '0;
              digit_cnt <= '0;
              tmo_cnt   <= TMO_INIT;
              state     <= GET_PIN;
            end
          end
        end

        GRANTED: begin
          if (bus.cancel) begin
            session_active_q <= 1'b0;
            session_index_q  <= '0;
            state            <= IDLE;
          end
        end

        LOCKED: ;  // held until rst

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.acc_num        = acc_num_q;
  assign bus.pin            = pin_q;
  assign bus.session_active = session_active_q;
  assign bus.session_index  = session_index_q;
  assign bus.locked         = locked_q;
  assign bus.pin_error      = pin_error_q;
  assign bus.attempts_left  = attempts_q;
  assign bus.state_out      = state;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pin_entry_ctrl
// Directed bench for pin_entry_ctrl (TIMEOUT_CYCLES = 8). Expected output
// values are queued as each stimulus step is driven and drained against the
// DUT at the following negative clock edge. A small account table stands in
// for the authenticator; a monitor counts pin_error pulses and flags any pulse
// longer than one cycle.
// -----------------------------------------------------------------------------
module tb_pin_entry_ctrl;

  localparam int S_IDLE = 0, S_GET = 1, S_CHECK = 2, S_GRANT = 3, S_LOCK = 4;

  typedef enum {
    F_STATE, F_ACC, F_PIN, F_ACTIVE, F_INDEX, F_LOCKED, F_PERR, F_TRIES,
    F_PE_COUNT, F_PE_LONG
  } field_e;

  typedef struct {
    field_e      f;
    logic [31:0] v;
  } exp_t;

  logic clk;
  logic rst;
  pin_entry_if bus_if ();

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   pe_count  = 0;
  int   pe_long   = 0;
  logic pe_prev   = 1'b0;

  pin_entry_ctrl #(
    .PIN_DIGITS    (4),
    .MAX_TRIES     (3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Authenticator stand-in: account -> (PIN, database index).
  always_comb begin
    bus_if.auth_found  = 1'b0;
    bus_if.auth_pin_ok = 1'b0;
    bus_if.auth_index  = 4'd0;
    case (bus_if.acc_num)
      4'd1: begin
        bus_if.auth_found  = 1'b1;
        bus_if.auth_pin_ok = (bus_if.pin == 16'd1234);
        bus_if.auth_index  = 4'd0;
      end
      4'd2: begin
        bus_if.auth_found  = 1'b1;
        bus_if.auth_pin_ok = (bus_if.pin == 16'd4321);
        bus_if.auth_index  = 4'd5;
      end
      4'd3: begin
        bus_if.auth_found  = 1'b1;
        bus_if.auth_pin_ok = (bus_if.pin == 16'd9012);
        bus_if.auth_index  = 4'd7;
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (bus_if.pin_error === 1'b1) begin
      pe_count <= pe_count + 1;
      if (pe_prev) pe_long <= pe_long + 1;
    end
    pe_prev <= (bus_if.pin_error === 1'b1);
  end

  function automatic logic [31:0] observe(input field_e f);
    case (f)
      F_STATE:    return 32'(bus_if.state_out);
      F_ACC:      return 32'(bus_if.acc_num);
      F_PIN:      return 32'(bus_if.pin);
      F_ACTIVE:   return 32'(bus_if.session_active);
      F_INDEX:    return 32'(bus_if.session_index);
      F_LOCKED:   return 32'(bus_if.locked);
      F_PERR:     return 32'(bus_if.pin_error);
      F_TRIES:    return 32'(bus_if.attempts_left);
      F_PE_COUNT: return 32'(pe_count);
      F_PE_LONG:  return 32'(pe_long);
      default:    return 'x;
    endcase
  endfunction

  task automatic push(input field_e f, input int v);
    exp_t e;
    e.f = f;
    e.v = 32'(v);
    sb_q.push_back(e);
  endtask

  // Drain every queued expectation against the DUT as it stands now.
  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.f);
      total_cnt++;
      assert (obs === e.v) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", e.f.name(), obs, e.v);
    end
  endtask

  task automatic push_reset_state();
    push(F_STATE, S_IDLE);  push(F_ACC, 0);    push(F_PIN, 0);
    push(F_ACTIVE, 0);      push(F_INDEX, 0);  push(F_LOCKED, 0);
    push(F_PERR, 0);        push(F_TRIES, 3);
  endtask

  task automatic card(input logic [3:0] acc);
    bus_if.card_in      = 1'b1;
    bus_if.card_acc_num = acc;
    @(negedge clk);
    bus_if.card_in      = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    bus_if.key_valid = 1'b1;
    bus_if.key_digit = d;
    @(negedge clk);
    bus_if.key_valid = 1'b0;
  endtask

  task automatic enter_pin(input logic [15:0] bcd);
    logic [15:0] b;
    b = bcd;
    for (int k = 3; k >= 0; k--) press(b[k*4 +: 4]);
  endtask

  task automatic pulse_cancel();
    bus_if.cancel = 1'b1;
    @(negedge clk);
    bus_if.cancel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                 = 1'b1;
    bus_if.card_in      = 1'b0;
    bus_if.card_acc_num = 4'd0;
    bus_if.key_valid    = 1'b0;
    bus_if.key_digit    = 4'd0;
    bus_if.key_clear    = 1'b0;
    bus_if.cancel       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_reset_state();
    check();

    // Account 1, correct PIN 1234: CHECK for two cycles, then GRANTED.
    card(4'd1);
    push(F_STATE, S_GET); push(F_ACC, 1); push(F_PIN, 0); push(F_TRIES, 3);
    check();
    enter_pin(16'h1234);
    push(F_STATE, S_CHECK); push(F_PIN, 1234); push(F_ACC, 1);
    check();
    @(negedge clk);
    push(F_STATE, S_CHECK); push(F_PIN, 1234); push(F_ACTIVE, 0);
    check();
    @(negedge clk);
    push(F_STATE, S_GRANT); push(F_ACTIVE, 1); push(F_INDEX, 0); push(F_PERR, 0);
    check();
    card(4'd9);                                   // ignored outside IDLE
    push(F_STATE, S_GRANT); push(F_ACC, 1);
    check();
    pulse_cancel();
    push(F_STATE, S_IDLE); push(F_ACTIVE, 0);
    check();

    // Account 3: clear (winning over a simultaneous key), non-BCD key ignored.
    card(4'd3);
    press(4'd5);
    press(4'd6);
    push(F_PIN, 56);
    check();
    bus_if.key_clear = 1'b1;
    bus_if.key_valid = 1'b1;
    bus_if.key_digit = 4'd7;
    @(negedge clk);
    bus_if.key_clear = 1'b0;
    bus_if.key_valid = 1'b0;
    push(F_PIN, 0); push(F_STATE, S_GET);
    check();
    press(4'd9);
    press(4'd0);
    press(4'd12);
    push(F_PIN, 90); push(F_STATE, S_GET);
    check();
    press(4'd1);
    press(4'd2);
    push(F_STATE, S_CHECK); push(F_PIN, 9012);
    check();
    repeat (2) @(negedge clk);
    push(F_STATE, S_GRANT); push(F_INDEX, 7); push(F_ACTIVE, 1);
    check();
    pulse_cancel();
    push(F_STATE, S_IDLE); push(F_INDEX, 0); push(F_ACTIVE, 0);
    check();

    // Timeout: two digits then silence; IDLE exactly 8 cycles after last key.
    card(4'd1);
    press(4'd1);
    press(4'd2);
    repeat (7) @(negedge clk);
    push(F_STATE, S_GET); push(F_PIN, 12);
    check();
    @(negedge clk);
    push(F_STATE, S_IDLE);
    check();

    // Cancel on the CHECK sample cycle beats a matching PIN.
    card(4'd1);
    enter_pin(16'h1234);
    @(negedge clk);
    pulse_cancel();
    push(F_STATE, S_IDLE); push(F_ACTIVE, 0); push(F_PERR, 0); push(F_INDEX, 0);
    check();

    // Unknown card: single pin_error, no try consumed, no lockout.
    card(4'd15);
    enter_pin(16'h1234);
    repeat (2) @(negedge clk);
    push(F_PERR, 1); push(F_STATE, S_IDLE); push(F_TRIES, 3); push(F_LOCKED, 0);
    check();
    @(negedge clk);
    push(F_PERR, 0);
    check();

    // Account 2: three wrong PINs lead to LOCKED.
    card(4'd2);
    for (int i = 0; i < 3; i++) begin
      enter_pin(16'h1111);
      repeat (2) @(negedge clk);
      push(F_PERR, 1);
      push(F_TRIES, 2 - i);
      if (i < 2) begin
        push(F_STATE, S_GET); push(F_PIN, 0); push(F_LOCKED, 0);
      end else begin
        push(F_STATE, S_LOCK); push(F_LOCKED, 1);
      end
      check();
      @(negedge clk);
      push(F_PERR, 0);
      check();
    end
    pulse_cancel();
    card(4'd1);
    push(F_STATE, S_LOCK); push(F_LOCKED, 1); push(F_ACC, 2); push(F_TRIES, 0);
    check();
    push(F_PE_COUNT, 4); push(F_PE_LONG, 0);
    check();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_reset_state();
    check();

    // Reset in the middle of CHECK.
    card(4'd1);
    enter_pin(16'h1234);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_reset_state();
    check();
    @(negedge clk);
    push(F_STATE, S_IDLE); push(F_ACTIVE, 0);
    check();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
